// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional overlap mode is selected with SEQ_DET_OVERLAP_EN.
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } seq_det_state_t;

    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 1)
            return 1;
        if (len > pat_w)
            return pat_w;
        return len;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked compare for seq_det_ctrl.
// SEQ_DET_OVERLAP_EN keeps the fill count across a match.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_x,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_hist_nx;
    logic [PAT_W-1:0] w_one;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_nx;

    assign w_one     = PAT_W'(1);
    assign w_hist_nx = (r_hist << 1) | PAT_W'(i_x);
    assign w_fill_nx = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
    // len == PAT_W shifts the one out, so the subtraction yields all ones
    assign w_mask    = (w_one << i_len) - w_one;

    assign o_hit = i_shift
                && (w_fill_nx >= i_len)
                && ((w_hist_nx & w_mask) == (i_pat & w_mask));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_nx;
`ifdef SEQ_DET_OVERLAP_EN
            r_fill <= w_fill_nx;
`else
            r_fill <= o_hit ? '0 : w_fill_nx;
`endif
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller (FSM, counters, config).
// Overlapping matches are counted when SEQ_DET_OVERLAP_EN is defined.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    seq_det_state_t   r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_tgt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_y;

    logic             w_cfg_hs;
    logic             w_start;
    logic             w_shift;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [LEN_W-1:0] w_len_cl;

    assign cfg_ready = (r_state != RUN);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign y         = r_y;
    assign match_cnt = r_cnt;

    assign w_cfg_hs = cfg_valid && cfg_ready;
    // a configuration offer always wins over start
    assign w_start  = start && !cfg_valid
                   && ((r_state == ARMED) || (r_state == DONE));
    assign w_shift  = (r_state == RUN) && x_valid && !abort;
    assign w_cnt_nx = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_len_cl = LEN_W'(clamp_len(int'(cfg_len), PAT_W));

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start),
        .i_shift (w_shift),
        .i_x     (x),
        .i_pat   (r_pat),
        .i_len   (r_len),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_len   <= LEN_W'(1);
            r_tgt   <= '0;
            r_cnt   <= '0;
            r_y     <= 1'b0;
        end else begin
            r_y <= 1'b0;
            if (w_cfg_hs) begin
                r_pat <= cfg_pattern;
                r_len <= w_len_cl;
                r_tgt <= cfg_target;
            end
            unique case (r_state)
                IDLE: begin
                    if (cfg_valid)
                        r_state <= ARMED;
                end
                ARMED: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= ARMED;
                    end else if (w_hit) begin
                        r_y   <= 1'b1;
                        r_cnt <= w_cnt_nx;
                        if ((r_tgt != '0) && (w_cnt_nx == r_tgt))
                            r_state <= DONE;
                    end
                end
                DONE: begin
                    if (cfg_valid) begin
                        r_state <= ARMED;
                    end else if (w_start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else if (abort) begin
                        r_state <= ARMED;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic
// against a queue-based behavioural model (honours SEQ_DET_OVERLAP_EN).
module tb_seq_det_ctrl;

    localparam int PW = 8;
    localparam int CW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_target;
    logic          start;
    logic          abort;
    logic          x;
    logic          x_valid;
    logic          y;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done;

    int errs   = 0;
    int checks = 0;
    int pulses;

    // model: 0 idle, 1 armed, 2 run, 3 done
    int          m_st;
    logic [7:0]  m_pat;
    int          m_len;
    int          m_tgt;
    int          m_cnt;
    bit          m_y;
    bit          q[$];

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W (PW),
        .CNT_W (CW),
        .LEN_W (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit h;
        if (rst) begin
            m_st = 0; m_pat = 0; m_len = 1; m_tgt = 0; m_cnt = 0; m_y = 0;
            q.delete();
            return;
        end
        m_y = 0;
        if (cfg_valid && m_st != 2) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : ((cfg_len > PW) ? PW : int'(cfg_len));
            m_tgt = cfg_target;
        end
        case (m_st)
            0: if (cfg_valid) m_st = 1;
            1: if (!cfg_valid && start) begin
                   m_st = 2; m_cnt = 0; q.delete();
               end
            2: begin
                if (abort) begin
                    m_st = 1;
                end else if (x_valid) begin
                    q.push_back(x);
                    if (q.size() > PW) void'(q.pop_front());
                    h = 0;
                    if (q.size() >= m_len) begin
                        h = 1;
                        for (int k = 0; k < m_len; k++)
                            if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k])
                                h = 0;
                    end
                    if (h) begin
                        m_y = 1;
                        if (m_cnt < 255) m_cnt++;
`ifndef SEQ_DET_OVERLAP_EN
                        q.delete();
`endif
                        if (m_tgt != 0 && m_cnt == m_tgt) m_st = 3;
                    end
                end
            end
            default: begin
                if (cfg_valid) m_st = 1;
                else if (start) begin
                    m_st = 2; m_cnt = 0; q.delete();
                end else if (abort) m_st = 1;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("y", y, m_y);
            chk("match_cnt", match_cnt, m_cnt);
            chk("busy", busy, m_st == 2);
            chk("done", done, m_st == 3);
            chk("cfg_ready", cfg_ready, m_st != 2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(bit cv = 0, bit st = 0, bit ab = 0,
                        bit xv = 0, bit xx = 0, bit r = 0);
        cfg_valid = cv; start = st; abort = ab;
        x_valid = xv; x = xx; rst = r;
        @(negedge clk);
    endtask

    task automatic setcfg(logic [PW-1:0] p, logic [LW-1:0] l, logic [CW-1:0] t);
        cfg_pattern = p; cfg_len = l; cfg_target = t;
    endtask

    task automatic sendbit(bit b, int gaps = 0);
        step(.xv(1), .xx(b));
        pulses += int'(y);
        for (int g = 0; g < gaps; g++) begin
            step();
            chk("gap_y", y, 1'b0);
        end
    endtask

    initial begin
        bit bits8 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        bit bits5 [5] = '{1, 0, 1, 0, 1};
        setcfg('0, '0, '0);
        step(.r(1));
        step(.r(1));
        step();
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_y", y, 1'b0);
        step(.st(1));
        chk("idle_start_ignored", busy, 1'b0);

        // basic match, target 2
        setcfg(8'b0001, 4, 2);
        step(.cv(1));
        step(.st(1));
        chk("start_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sendbit(bits8[i]);
            if (i == 3) begin
                chk("basic_y1", y, 1'b1);
                chk("basic_cnt1", match_cnt, 1);
            end
        end
        chk("basic_y2", y, 1'b1);
        chk("basic_cnt2", match_cnt, 2);
        chk("basic_done", done, 1'b1);
        chk("basic_busy", busy, 1'b0);

        // overlap
        setcfg(8'b101, 3, 0);
        step(.cv(1));
        step(.st(1));
        pulses = 0;
        for (int i = 0; i < 5; i++) sendbit(bits5[i]);
`ifdef SEQ_DET_OVERLAP_EN
        chk("ovl_cnt", match_cnt, 2);
        chk("ovl_pulses", pulses, 2);
`else
        chk("ovl_cnt", match_cnt, 1);
        chk("ovl_pulses", pulses, 1);
`endif

        // gaps on x_valid
        step(.ab(1));
        setcfg(8'b0001, 4, 2);
        step(.cv(1));
        step(.st(1));
        pulses = 0;
        for (int i = 0; i < 8; i++) sendbit(bits8[i], 2);
        chk("gap_pulses", pulses, 2);
        chk("gap_cnt", match_cnt, 2);
        chk("gap_done", done, 1'b1);

        // abort beats match
        setcfg(8'b0001, 4, 0);
        step(.cv(1));
        step(.st(1));
        sendbit(0); sendbit(0); sendbit(0);
        step(.ab(1), .xv(1), .xx(1));
        chk("abort_y", y, 1'b0);
        chk("abort_cnt", match_cnt, 0);
        chk("abort_ready", cfg_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);

        // reset mid-run
        step(.st(1));
        sendbit(1); sendbit(0); sendbit(1);
        step(.r(1));
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_cnt", match_cnt, 0);
        chk("mrst_y", y, 1'b0);
        chk("mrst_ready", cfg_ready, 1'b1);
        step(.st(1));
        chk("mrst_start_ignored", busy, 1'b0);

        // length clamp and cfg/start priority
        setcfg(8'h01, 0, 0);
        step(.cv(1));
        step(.cv(1), .st(1));
        chk("prio_busy", busy, 1'b0);
        chk("prio_ready", cfg_ready, 1'b1);
        step(.st(1));
        chk("clamp_busy", busy, 1'b1);
        sendbit(1);
        chk("clamp_y", y, 1'b1);
        chk("clamp_cnt", match_cnt, 1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 14) == 0)
                setcfg(PW'($urandom), LW'($urandom_range(0, 10)),
                       CW'($urandom_range(0, 3)));
            step(.cv($urandom_range(0, 14) == 0),
                 .st($urandom_range(0, 9) == 0),
                 .ab($urandom_range(0, 39) == 0),
                 .xv($urandom_range(0, 9) < 7),
                 .xx(1'($urandom)),
                 .r($urandom_range(0, 299) == 0));
        end

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller. It generalises the team's fixed-pattern sequence detectors into one configurable engine. A host loads a pattern, a length and a target match count over a valid/ready handshake, then arms and starts detection on the serial input. The block counts matches, pulses `y` per match, and stops with `done` once the target is reached. It sits between the control/register side and the serial bit stream.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits.
- `CNT_W`, default 8: width of the target and match counters.
- `LEN_W`, default $clog2(PAT_W)+1: width of `cfg_len`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  configuration accepted when high with `cfg_valid`.
- `cfg_pattern`  in  PAT_W  pattern; bit `len-1` is received first, bit 0 last.
- `cfg_len`  in  LEN_W  pattern length, 1..PAT_W.
- `cfg_target`  in  CNT_W  matches until done; 0 means unlimited.
- `start`  in  1  one-cycle start request.
- `abort`  in  1  one-cycle stop request.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is sampled when high.
- `y`  out  1  one-cycle match pulse.
- `match_cnt`  out  CNT_W  matches since the last start.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
States: IDLE, ARMED, RUN, DONE.

- **IDLE**
  - `cfg_ready`=1.
  - A handshake latches pattern, len and target, then goes to ARMED.
  - `start` is ignored.
- **ARMED**
  - `cfg_ready`=1; a handshake reloads the configuration and stays in ARMED.
  - `start` goes to RUN and clears history, fill count and `match_cnt`.
  - If `cfg_valid` and `start` arrive together, the configuration is taken and `start` is ignored.
- **RUN**
  - `cfg_ready`=0.
  - Each `x_valid` cycle shifts `x` into the history LSB and increments the fill count, saturating at PAT_W.
  - Match condition: fill ≥ len and history[len-1:0] == pattern[len-1:0], evaluated on the shifted-in value.
  - On a match, `y` pulses and `match_cnt` increments, saturating at all-ones.
  - When `match_cnt` reaches a nonzero target, go to DONE.
  - `abort` goes to ARMED. Configuration and `match_cnt` are retained. Abort beats a match in the same cycle: no `y`, no increment.
- **DONE**
  - `done`=1 and `cfg_ready`=1.
  - `start` goes to RUN with counters cleared.
  - A configuration handshake goes to ARMED; it has priority over `start`.
  - `abort` goes to ARMED.

Configuration values:
- `cfg_len`=0 is clamped to 1.
- `cfg_len`>PAT_W is clamped to PAT_W.
- Pattern bits above len are don't-care.

Cycles with `x_valid`=0 leave the history, fill count and outputs unchanged, except that `y` returns to 0.

## Timing
- Reset values:
  - Outputs: `y`=0, `match_cnt`=0, `busy`=0, `done`=0, `cfg_ready`=1 (state IDLE).
  - Internal: history=0, fill=0, pattern=0, len=1, target=0.
- Reset mid-operation returns to the reset values on the next edge.
- Match latency: `x` is sampled at edge N; `y` and the incremented `match_cnt` are visible after edge N, for one cycle.
- `done` rises on the same edge as the final `y`. `busy` falls on that edge.
- Start latency: `start` at edge N gives `busy`=1 after edge N; the first bit is sampled at edge N+1.
- `cfg_ready` is a registered state decode and does not depend combinationally on `cfg_valid`.
- Back-to-back matches can pulse `y` on consecutive cycles (overlap mode).

## Configuration
- Macro `SEQ_DET_OVERLAP_EN`.
- **Defined:** history and fill count are kept after a match, so overlapping occurrences are each counted.
- **Undefined:** the fill count clears to 0 on a match, so the next match needs len fresh valid bits.

## Structure
- Package `seq_det_pkg` holds:
  - the state enum type `seq_det_state_t` (IDLE, ARMED, RUN, DONE);
  - the default PAT_W and CNT_W localparams;
  - the clamp-length function.
- One sub-module, `seq_match_core`. It contains the history shift register, the fill counter and the masked compare, and outputs a combinational `hit`. The controller FSM, counters and handshake live in `seq_det_ctrl`.

## Test plan
- **Basic match, target reached:** load pattern 0001 (len 4, target 2), start, stream 0,0,0,1,0,0,0,1. Expect `y` after the 4th and 8th bits, `match_cnt` 1 then 2, and `done`=1 with `busy`=0 after the 8th bit.
- **Overlap:** pattern 101, len 3, target 0, stream 1,0,1,0,1. With `SEQ_DET_OVERLAP_EN`, 2 `y` pulses and `match_cnt`=2. Without it, 1 pulse and `match_cnt`=1.
- **Gaps on `x_valid`:** repeat the basic-match scenario with two `x_valid`=0 cycles between each bit. Expect an identical match sequence, and `y` never high during gap cycles except the cycle directly after a matching bit.
- **Abort beats match:** assert `abort` on the edge sampling the completing bit of 0001. Expect no `y`, `match_cnt` unchanged, state ARMED and `cfg_ready`=1.
- **Reset mid-run:** assert `rst` after 3 bits in RUN. Next cycle expect `busy`=0, `match_cnt`=0, `y`=0, `cfg_ready`=1, and `start` ignored until a new configuration is loaded.
- **Length clamp and priority:** load `cfg_len`=0 with pattern 1, and drive `cfg_valid` and `start` in the same ARMED cycle. Expect the configuration taken and `start` ignored. Then start, send bit 1, and expect a `y` pulse.
